// File: rtl/mux_scan_nt1.sv
// mux_scan_nt1: registered N-to-1 selector with manual select and automatic channel scan
module mux_scan_nt1 #(
    parameter int WIDTH = 32,
    parameter int NUM   = 8,
    parameter int SELW  = 3,
    parameter int DIV   = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM*WIDTH-1:0] I,
    input  logic [SELW-1:0]      s,
    input  logic                 mode,
    input  logic [NUM-1:0]       en_mask,
    input  logic                 hold,
    output logic [WIDTH-1:0]     O,
    output logic [SELW-1:0]      ch,
    output logic                 strobe
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int MW = 2 ** SELW;
    localparam logic [CW-1:0] TC = CW'(DIV - 1);

    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] chan [MW];
    logic [MW-1:0]    msk;
    logic [SELW-1:0]  nxt_en;
    logic [SELW-1:0]  ch_next;
    logic             found;
    logic             none;
    int               base;

    // Channels beyond NUM read as zero so any select value indexes safely
    for (genvar k = 0; k < MW; k++) begin : g_chan
        if (k < NUM) begin : g_in
            assign chan[k] = I[k*WIDTH +: WIDTH];
        end else begin : g_pad
            assign chan[k] = '0;
        end
    end

    assign msk  = MW'(en_mask);
    assign none = ~|en_mask;

    // Next enabled channel above ch with wrap; an out-of-range ch starts the search at 0
    always_comb begin
        nxt_en = ch;
        found  = 1'b0;
        base   = (int'(ch) < NUM) ? int'(ch) : NUM - 1;
        for (int i = 1; i <= NUM; i++) begin
            if (!found && msk[SELW'((base + i) % NUM)]) begin
                found  = 1'b1;
                nxt_en = SELW'((base + i) % NUM);
            end
        end
    end

    // Channel chosen for this edge: manual select, or scan advance at terminal count
    always_comb begin
        ch_next = mode ? ((!hold && cnt == TC) ? nxt_en : ch) : s;
    end

    // Dwell divider, channel pointer, registered data and change strobe
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt    <= '0;
            ch     <= '0;
            O      <= '0;
            strobe <= 1'b0;
        end else begin
            cnt    <= !mode ? '0 : hold ? cnt : (cnt == TC) ? '0 : cnt + 1'b1;
            ch     <= ch_next;
            O      <= (mode && none) ? '0 : chan[ch_next];
            strobe <= ch_next != ch;
        end
    end
endmodule

// File: tb/tb_mux_scan_nt1.sv
// tb_mux_scan_nt1: directed scoreboard bench for the manual/scan channel selector
module tb_mux_scan_nt1;
    localparam int WIDTH = 32;
    localparam int NUM   = 8;
    localparam int SELW  = 4;
    localparam int DIV   = 4;

    typedef struct {
        logic [WIDTH-1:0] o;
        logic [SELW-1:0]  c;
        logic             st;
        string            nm;
    } exp_t;

    logic                 clk = 1'b0;
    logic                 rst = 1'b1;
    logic [NUM*WIDTH-1:0] I;
    logic [SELW-1:0]      s = '0;
    logic                 mode = 1'b0;
    logic [NUM-1:0]       en_mask = '1;
    logic                 hold = 1'b0;
    logic [WIDTH-1:0]     O;
    logic [SELW-1:0]      ch;
    logic                 strobe;

    exp_t q[$];
    int   tests = 0;
    int   fails = 0;

    mux_scan_nt1 #(.WIDTH(WIDTH), .NUM(NUM), .SELW(SELW), .DIV(DIV)) dut (
        .clk(clk), .rst(rst), .I(I), .s(s), .mode(mode),
        .en_mask(en_mask), .hold(hold), .O(O), .ch(ch), .strobe(strobe)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] ev(input int k);
        return (k < NUM) ? WIDTH'(32'h1111_1111 * k) : '0;
    endfunction

    task automatic chk(input string nm, input logic [WIDTH-1:0] eo, input logic [SELW-1:0] ec, input logic est);
        tests++;
        if (O !== eo || ch !== ec || strobe !== est) begin
            fails++;
            $display("FAIL %s: got O=%h ch=%0d strobe=%b, want O=%h ch=%0d strobe=%b",
                     nm, O, ch, strobe, eo, ec, est);
        end
    endtask

    // push the expectation for the coming edge, then advance to just after it
    task automatic cyc(input logic [WIDTH-1:0] eo, input int ec, input logic est, input string nm);
        exp_t e;
        e.o = eo; e.c = SELW'(ec); e.st = est; e.nm = nm;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask

    // one full scan dwell: DIV-1 cycles on 'from', then the terminal-count edge lands on 'to'
    task automatic scan_step(input int from, input int to, input string nm);
        for (int i = 0; i < DIV - 1; i++) cyc(ev(from), from, 1'b0, {nm, "_dwell"});
        cyc(ev(to), to, 1'(from != to), {nm, "_adv"});
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                exp_t e;
                e = q.pop_front();
                chk(e.nm, e.o, e.c, e.st);
            end
        end
    end

    initial begin
        for (int k = 0; k < NUM; k++) I[k*WIDTH +: WIDTH] = ev(k);
        #12;
        chk("reset", '0, '0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        // manual mode
        cyc('0, 0, 1'b0, "post_rst");
        s = 4'd5;
        cyc(ev(5), 5, 1'b1, "man5");
        cyc(ev(5), 5, 1'b0, "man5_held");
        s = 4'd9;
        cyc('0, 9, 1'b1, "oor9");
        cyc('0, 9, 1'b0, "oor9_held");
        s = 4'd0;
        cyc('0, 0, 1'b1, "man0");
        // full rotation
        mode = 1'b1;
        en_mask = 8'hFF;
        for (int k = 0; k < NUM; k++) scan_step(k, (k + 1) % NUM, "rot");
        // masked rotation 0,2,7,0,2
        en_mask = 8'b1000_0101;
        scan_step(0, 2, "m02");
        scan_step(2, 7, "m27");
        scan_step(7, 0, "m70");
        scan_step(0, 2, "m02b");
        cyc(ev(2), 2, 1'b0, "mid_c1");
        en_mask = 8'b1000_0001;
        cyc(ev(2), 2, 1'b0, "dis_c2");
        cyc(ev(2), 2, 1'b0, "dis_c3");
        cyc(ev(7), 7, 1'b1, "dis_skip");
        // all channels disabled: ch frozen, O zero, divider keeps running (ends at cnt=2)
        en_mask = '0;
        for (int i = 0; i < 6; i++) cyc('0, 7, 1'b0, "mask0");
        // hold with live data on the frozen channel
        en_mask = 8'hFF;
        hold = 1'b1;
        for (int i = 0; i < 10; i++) begin
            I[7*WIDTH +: WIDTH] = 32'hA5A5_0000 + 32'(i);
            cyc(32'hA5A5_0000 + 32'(i), 7, 1'b0, "hold");
        end
        hold = 1'b0;
        I[7*WIDTH +: WIDTH] = ev(7);
        cyc(ev(7), 7, 1'b0, "unhold_c3");
        cyc(ev(0), 0, 1'b1, "unhold_adv");
        // mode switch at ch=3, cnt=1
        scan_step(0, 1, "ms01");
        scan_step(1, 2, "ms12");
        scan_step(2, 3, "ms23");
        cyc(ev(3), 3, 1'b0, "ms_c1");
        mode = 1'b0;
        s = 4'd6;
        cyc(ev(6), 6, 1'b1, "to_man6");
        mode = 1'b1;
        scan_step(6, 7, "back_scan");
        // scan entry from an out-of-range channel
        mode = 1'b0;
        s = 4'd9;
        cyc('0, 9, 1'b1, "man9");
        mode = 1'b1;
        scan_step(9, 0, "oor_entry");
        // single enabled channel
        en_mask = 8'b0001_0000;
        scan_step(0, 4, "single_in");
        scan_step(4, 4, "single_stay");
        // asynchronous reset between edges
        en_mask = 8'hFF;
        cyc(ev(4), 4, 1'b0, "pre_rst");
        #1;
        rst = 1'b1;
        #1;
        chk("async_rst", '0, '0, 1'b0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        scan_step(0, 1, "post_async");
        repeat (2) @(posedge clk);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending, want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mux_scan_nt1.md
Name: mux_scan_nt1

Overview:
- Parametrised, registered N-to-1 data selector for the datapath and display paths.
- Manual mode: output follows an externally supplied select.
- Scan mode: an internal divider/counter rotates through the enabled channels automatically (display multiplexing, debug bus sweep).
- Outputs are registered, with a channel index and a channel-change strobe.

Parameters:
WIDTH, 32, data width of each channel and of O
NUM, 8, number of input channels (2..16)
SELW, 3, select/index width; must satisfy 2**SELW >= NUM
DIV, 4, clock cycles spent on each channel in scan mode (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
I  input  NUM*WIDTH  flattened channel inputs; channel k = I[k*WIDTH +: WIDTH]
s  input  SELW  manual channel select
mode  input  1  0 = manual, 1 = scan
en_mask  input  NUM  per-channel enable used in scan mode; bit k enables channel k
hold  input  1  scan mode only: freeze divider and channel pointer
O  output  WIDTH  registered selected data
ch  output  SELW  registered index of channel currently driving O
strobe  output  1  one-cycle pulse: ch changed on this edge

Behaviour:
- Reset (async, any time, including mid-scan):
  - O=0, ch=0, strobe=0.
  - Internal divider cnt=0.
  - Release takes effect on the next rising edge.
- O update, every cycle after reset:
  - O <= I[ch_next] when ch_next < NUM; otherwise O <= 0.
  - O therefore reflects the newly selected channel in the same edge ch updates: 1-cycle latency from s (manual) or from terminal count (scan).
  - O keeps tracking live data on the held channel while the channel does not change.
- Manual mode (mode=0):
  - ch_next = s; cnt <= 0.
  - s >= NUM: ch <= s, O <= 0.
  - en_mask and hold are ignored.
- Scan mode (mode=1):
  - cnt counts 0..DIV-1 and wraps.
  - At cnt==DIV-1 (terminal count), ch_next = the next index after ch, searching upward with wrap NUM-1 -> 0, whose en_mask bit is 1.
  - Other cycles: ch_next = ch.
  - Only one enabled channel: ch_next is that channel, and strobe pulses only if ch differed from it.
  - en_mask all zero: ch holds, O <= 0, strobe=0, cnt keeps running.
  - Current ch disabled mid-dwell: O still shows I[ch] until terminal count, then ch advances to the next enabled channel.
  - ch >= NUM on entry (from a manual out-of-range s): treated as disabled; advances at terminal count.
  - hold=1: cnt and ch frozen, O keeps registering I[ch]. Terminal count reached while holding does not advance ch.
  - DIV=1: advance every cycle.
- Mode transitions:
  - manual -> scan: first edge in scan mode starts with cnt=0 from current ch; first advance after DIV cycles.
  - scan -> manual: on the first manual edge, ch <= s and cnt <= 0.
- strobe:
  - Registered; strobe <= (ch_next != ch). Applies in both modes.
  - Never asserted in the reset cycle or on the first edge after reset unless ch actually changes.
- Widths:
  - cnt width is clog2(DIV), minimum 1.
  - All index comparisons are unsigned on SELW bits.

Test Plan:
- Reset/manual: WIDTH=32, NUM=8, I[k]=32'h1111_1111*k, rst pulse. Then mode=0, s=5 -> one edge later O=32'h5555_5555, ch=5, strobe=1 for one cycle. s held -> strobe=0. Set s=9 with SELW=4, NUM=8 -> O=0, ch=9.
- Scan rotation: mode=1, DIV=4, en_mask=8'b1111_1111 from ch=0 -> ch steps 0,1,...,7,0 every 4 cycles, strobe pulses each step, O=I[ch] with no extra delay.
- Masked scan: en_mask=8'b1000_0101 -> ch sequence 0,2,7,0,... Clear the bit of the current channel mid-dwell -> skip at the next terminal count. en_mask=0 -> O=0, ch frozen, strobe=0.
- Hold: in scan mode, assert hold at cnt=2 for 10 cycles -> ch unchanged, O follows changing I[ch]. Release -> advance after 2 more cycles.
- Mode switch: scan at ch=3, cnt=1, switch to mode=0 with s=6 -> next edge ch=6, strobe=1. Back to mode=1 -> first advance exactly DIV cycles later, to ch=7.
- Async reset mid-scan: assert rst between clock edges at ch=4 -> O=0, ch=0, strobe=0 immediately, without waiting for a clock edge. After release, scan resumes 0->1 after DIV cycles.
